sensor_tx_scheduler: RTL and testbench

- Round-robin scheduler for the 8-sensor polled link.
- Picks the next sensor with fresh data and drives the 3-bit address into the 8:1 sensor mux.
- Captures the selected byte, builds the 11-bit {data, address} packet plus an even-parity bit, and hands it to the transmitter with a valid/ready handshake.
- Waits for the receiver's parity-check verdict, retransmits on error or timeout up to a limit, then reports done or drop back to the requesting sensor.

---
 rtl/sensor_tx_scheduler.sv | 133 +++++++++++++
 tb/tb_sensor_tx_scheduler.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/sensor_tx_scheduler.sv
// rtl/sensor_tx_scheduler.sv - round-robin sensor poller with parity-checked retransmit
module sensor_tx_scheduler #(
  parameter int MAX_RETRY   = 3,
  parameter int ACK_TIMEOUT = 15
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  sensor_req,
  input  logic [7:0]  enable_mask,
  input  logic [7:0]  mux_data,
  input  logic        tx_ready,
  input  logic        rx_ack,
  input  logic        rx_err,
  output logic [2:0]  addr_out,
  output logic [10:0] packet_out,
  output logic        parity_out,
  output logic        pkt_valid,
  output logic [7:0]  sensor_done,
  output logic [7:0]  sensor_drop,
  output logic        busy,
  output logic [7:0]  drop_count
);

  typedef enum logic [1:0] {IDLE, LOAD, SEND, WAIT_ACK} state_t;

  state_t      state, state_nxt;
  logic [2:0]  rr_ptr, rr_ptr_nxt;
  logic [2:0]  addr_nxt;
  logic [2:0]  retry_cnt, retry_nxt;
  logic [7:0]  timer, timer_nxt;
  logic [10:0] packet_nxt;
  logic        parity_nxt;
  logic [7:0]  done_nxt, drop_nxt, drop_count_nxt;
  logic [7:0]  elig;
  logic [2:0]  winner;
  logic        found;
  logic        wait_err;

  assign elig      = sensor_req & enable_mask;
  assign pkt_valid = (state == SEND);
  assign busy      = (state != IDLE);
  assign wait_err  = rx_err || (timer == 8'(ACK_TIMEOUT - 1));

  // Search starts just past the last winner; i == 8 wraps back onto rr_ptr itself.
  always_comb begin
    winner = rr_ptr;
    found  = 1'b0;
    for (int i = 1; i <= 8; i++) begin
      if (!found && elig[rr_ptr + 3'(i)]) begin
        winner = rr_ptr + 3'(i);
        found  = 1'b1;
      end
    end
  end

  always_comb begin
    state_nxt      = state;
    rr_ptr_nxt     = rr_ptr;
    addr_nxt       = addr_out;
    retry_nxt      = retry_cnt;
    timer_nxt      = timer;
    packet_nxt     = packet_out;
    parity_nxt     = parity_out;
    done_nxt       = 8'h00;
    drop_nxt       = 8'h00;
    drop_count_nxt = drop_count;
    case (state)
      IDLE: begin
        if (found) begin
          addr_nxt   = winner;
          rr_ptr_nxt = winner;
          retry_nxt  = 3'd0;
          state_nxt  = LOAD;
        end
      end
      LOAD: begin
        packet_nxt = {mux_data, addr_out};
        parity_nxt = ^mux_data;
        state_nxt  = SEND;
      end
      SEND: begin
        if (tx_ready) begin
          timer_nxt = 8'd0;
          state_nxt = WAIT_ACK;
        end
      end
      WAIT_ACK: begin
        timer_nxt = timer + 8'd1;
        if (wait_err) begin
          if (retry_cnt < 3'(MAX_RETRY)) begin
            retry_nxt = retry_cnt + 3'd1;
            state_nxt = SEND;
          end else begin
            drop_nxt       = 8'h01 << addr_out;
            drop_count_nxt = (drop_count == 8'hFF) ? drop_count : drop_count + 8'd1;
            state_nxt      = IDLE;
          end
        end else if (rx_ack) begin
          done_nxt  = 8'h01 << addr_out;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      rr_ptr      <= 3'd7;
      addr_out    <= 3'd0;
      retry_cnt   <= 3'd0;
      timer       <= 8'd0;
      packet_out  <= 11'd0;
      parity_out  <= 1'b0;
      sensor_done <= 8'h00;
      sensor_drop <= 8'h00;
      drop_count  <= 8'h00;
    end else begin
      state       <= state_nxt;
      rr_ptr      <= rr_ptr_nxt;
      addr_out    <= addr_nxt;
      retry_cnt   <= retry_nxt;
      timer       <= timer_nxt;
      packet_out  <= packet_nxt;
      parity_out  <= parity_nxt;
      sensor_done <= done_nxt;
      sensor_drop <= drop_nxt;
      drop_count  <= drop_count_nxt;
    end
  end

endmodule

// File: tb/tb_sensor_tx_scheduler.sv
// tb/tb_sensor_tx_scheduler.sv - scoreboard bench for sensor_tx_scheduler
module tb_sensor_tx_scheduler;

  localparam int MAX_RETRY   = 3;
  localparam int ACK_TIMEOUT = 15;
  localparam int K_ACK = 0, K_ERR = 1, K_TO = 2, K_BOTH = 3;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [7:0]  sensor_req = 8'h00;
  logic [7:0]  enable_mask = 8'h00;
  logic [7:0]  mux_data;
  logic        tx_ready = 1'b0;
  logic        rx_ack = 1'b0;
  logic        rx_err = 1'b0;
  logic [2:0]  addr_out;
  logic [10:0] packet_out;
  logic        parity_out;
  logic        pkt_valid;
  logic [7:0]  sensor_done;
  logic [7:0]  sensor_drop;
  logic        busy;
  logic [7:0]  drop_count;

  logic [7:0]  sensor_bytes [8];
  assign mux_data = sensor_bytes[addr_out];

  sensor_tx_scheduler #(.MAX_RETRY(MAX_RETRY), .ACK_TIMEOUT(ACK_TIMEOUT)) dut (
    .clk(clk), .rst_n(rst_n), .sensor_req(sensor_req), .enable_mask(enable_mask),
    .mux_data(mux_data), .tx_ready(tx_ready), .rx_ack(rx_ack), .rx_err(rx_err),
    .addr_out(addr_out), .packet_out(packet_out), .parity_out(parity_out),
    .pkt_valid(pkt_valid), .sensor_done(sensor_done), .sensor_drop(sensor_drop),
    .busy(busy), .drop_count(drop_count)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass = 0;
  logic [11:0] pkt_q [$];
  logic [23:0] evt_q [$];
  int model_ptr = 7;
  int model_drops = 0;
  int verdict [8];
  bit scramble_req = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic set_all(input int k);
    for (int i = 0; i < 8; i++) verdict[i] = k;
  endtask

  function automatic int pick(input logic [7:0] elig);
    for (int k = 1; k <= 8; k++)
      if (elig[(model_ptr + k) % 8]) return (model_ptr + k) % 8;
    return 0;
  endfunction

  // Scoreboard monitor: packets at handshake, pulses whenever present.
  always @(negedge clk) begin
    logic [11:0] ep;
    logic [23:0] ee;
    if (pkt_valid && tx_ready) begin
      if (pkt_q.size() == 0) begin
        n_checks++;
        $display("FAIL pkt_unexpected: got %0h expected none", {packet_out, parity_out});
      end else begin
        ep = pkt_q.pop_front();
        chk("pkt", {packet_out, parity_out}, ep);
        chk("addr", addr_out, ep[3:1]);
      end
    end
    if (sensor_done != 8'h00 || sensor_drop != 8'h00) begin
      if (evt_q.size() == 0) begin
        n_checks++;
        $display("FAIL evt_unexpected: got done %0h drop %0h expected none", sensor_done, sensor_drop);
      end else begin
        ee = evt_q.pop_front();
        chk("done", sensor_done, ee[23:16]);
        chk("drop", sensor_drop, ee[15:8]);
        chk("drop_count", drop_count, ee[7:0]);
      end
    end
  end

  task automatic run_txn(input logic [7:0] req, input logic [7:0] mask, input int hold);
    int w, n_att, cnt, h, d;
    logic [7:0] b;
    bit done_ok;
    w = pick(req & mask);
    model_ptr = w;
    b = sensor_bytes[w];
    done_ok = 1'b0;
    n_att = 0;
    for (int a = 0; a <= MAX_RETRY; a++) begin
      pkt_q.push_back({b, 3'(w), ^b});
      n_att++;
      if (verdict[a] == K_ACK) begin
        done_ok = 1'b1;
        break;
      end
    end
    if (done_ok) evt_q.push_back({8'(1 << w), 8'h00, 8'(model_drops)});
    else begin
      if (model_drops < 255) model_drops++;
      evt_q.push_back({8'h00, 8'(1 << w), 8'(model_drops)});
    end

    chk("idle_before", busy, 0);
    sensor_req = req;
    enable_mask = mask;
    cnt = 0;
    while (!pkt_valid && cnt < 10) begin
      step;
      cnt++;
    end
    chk("latency", cnt, 2);
    sensor_bytes[w] = ~b;
    for (int a = 0; a < n_att; a++) begin
      h = (hold >= 0) ? hold : int'($urandom_range(0, 3));
      for (int i = 0; i < h; i++) begin
        rx_ack = ($urandom_range(0, 1) == 1);
        step;
      end
      rx_ack = 1'b0;
      if (h > 0) chk("hold_valid", pkt_valid, 1);
      tx_ready = 1'b1;
      step;
      tx_ready = 1'b0;
      if (scramble_req) sensor_req = 8'($urandom);
      if (verdict[a] == K_TO) begin
        cnt = 0;
        while (!pkt_valid && sensor_drop == 8'h00 && cnt < 40) begin
          step;
          cnt++;
        end
        chk("timeout_cycles", cnt, ACK_TIMEOUT);
      end else begin
        d = int'($urandom_range(0, 4));
        repeat (d) step;
        rx_ack = (verdict[a] == K_ACK || verdict[a] == K_BOTH);
        rx_err = (verdict[a] == K_ERR || verdict[a] == K_BOTH);
        step;
        rx_ack = 1'b0;
        rx_err = 1'b0;
      end
      if (a < n_att - 1) chk("resend_valid", pkt_valid, 1);
    end
    chk("busy_after", busy, 0);
    sensor_req = 8'h00;
    step;
  endtask

  initial begin
    #3000000;
    $display("FAIL watchdog: run did not complete");
    $fatal(1);
  end

  initial begin
    logic [7:0] rq, mk, b;
    int cnt, k;
    for (int i = 0; i < 8; i++) sensor_bytes[i] = 8'($urandom);
    sensor_bytes[2] = 8'hA5;
    repeat (2) step;
    chk("rst_addr", addr_out, 0);
    chk("rst_packet", packet_out, 0);
    chk("rst_parity", parity_out, 0);
    chk("rst_valid", pkt_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", sensor_done, 0);
    chk("rst_drop", sensor_drop, 0);
    chk("rst_drop_count", drop_count, 0);
    rst_n = 1'b1;
    step;

    set_all(K_ACK);
    run_txn(8'h04, 8'hFF, 0);
    repeat (4) run_txn(8'h81, 8'hFF, -1);
    repeat (4) run_txn(8'hFF, 8'h0A, -1);

    set_all(K_ERR);
    run_txn(8'h40, 8'hFF, 0);
    set_all(K_ACK); verdict[0] = K_ERR;
    run_txn(8'h08, 8'hFF, -1);
    set_all(K_ACK); verdict[0] = K_TO;
    run_txn(8'h02, 8'hFF, -1);
    set_all(K_ACK); verdict[0] = K_BOTH;
    run_txn(8'h10, 8'hFF, -1);
    set_all(K_TO);
    run_txn(8'h01, 8'hFF, 0);
    set_all(K_ACK);
    run_txn(8'h20, 8'hFF, 20);

    scramble_req = 1'b1;
    repeat (60) begin
      for (int i = 0; i < 8; i++) sensor_bytes[i] = 8'($urandom);
      do begin
        rq = 8'($urandom);
        mk = 8'($urandom);
      end while ((rq & mk) == 8'h00);
      for (int a = 0; a < 8; a++) begin
        k = int'($urandom_range(0, 6));
        verdict[a] = (k <= 2) ? K_ACK : (k == 3) ? K_ERR : (k == 4) ? K_TO : K_BOTH;
      end
      run_txn(rq, mk, -1);
    end
    scramble_req = 1'b0;

    // Abort mid-WAIT_ACK with reset; the pending request must restart from rr_ptr=7.
    set_all(K_ACK);
    b = sensor_bytes[4];
    model_ptr = 4;
    pkt_q.push_back({b, 3'd4, ^b});
    sensor_req = 8'h10;
    enable_mask = 8'hFF;
    cnt = 0;
    while (!pkt_valid && cnt < 10) begin
      step;
      cnt++;
    end
    chk("abort_latency", cnt, 2);
    tx_ready = 1'b1;
    step;
    tx_ready = 1'b0;
    repeat (2) step;
    rst_n = 1'b0;
    #1;
    chk("abort_valid", pkt_valid, 0);
    chk("abort_busy", busy, 0);
    chk("abort_addr", addr_out, 0);
    chk("abort_packet", packet_out, 0);
    chk("abort_parity", parity_out, 0);
    chk("abort_pulses", {sensor_done, sensor_drop}, 0);
    chk("abort_drop_count", drop_count, 0);
    model_ptr = 7;
    model_drops = 0;
    sensor_req = 8'h90;
    repeat (2) step;
    rst_n = 1'b1;
    run_txn(8'h90, 8'hFF, -1);

    set_all(K_ERR);
    repeat (256) begin
      rq = 8'($urandom) | 8'h01;
      run_txn(rq, 8'hFF, 0);
    end
    chk("drop_sat", drop_count, 255);
    set_all(K_ACK);
    run_txn(8'h33, 8'hFF, -1);
    chk("drop_sat_hold", drop_count, 255);

    repeat (3) step;
    chk("pkt_q_empty", pkt_q.size(), 0);
    chk("evt_q_empty", evt_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
